// File: rtl/memory_burst_pkg.sv
// Shared constants and FSM encoding for the burst reader and its port-A writer counterpart.
package memory_burst_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 16;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_BEATS      = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2,
      StHold  = 2'd3
   } state_t;

endpackage

// File: rtl/memory_burst_reader_rising_edge_detect.sv
// Single-cycle pulse on a rising edge of a level input.
// The previous sample resets high so a level already high at reset release is ignored.
module rising_edge_detect (
   input  logic i_clk,
   input  logic i_reset,  // active-low, asynchronous
   input  logic i_in,
   output logic o_pulse
);

   logic r_prev;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= i_in;
      end
   end

   assign o_pulse = i_in & ~r_prev;

endmodule

// File: rtl/memory_burst_reader.sv
// Reads BEATS consecutive words from memory port B and assembles them into one wide word,
// presented under a valid/ready handshake.
module memory_burst_reader
   import memory_burst_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned BEATS        = DEF_BEATS,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                        i_clk,
   input  logic                        i_reset,  // active-low, asynchronous
   input  logic                        i_trigger,
   input  logic [ADDR_WIDTH-1:0]       i_base_addr,
   output logic                        o_mem_en_b,
   output logic                        o_mem_we_b,
   output logic [ADDR_WIDTH-1:0]       o_mem_addr_b,
   input  logic [DATA_WIDTH-1:0]       i_mem_dout_b,
   output logic [BEATS*DATA_WIDTH-1:0] o_data_out,
   output logic                        o_data_valid,
   input  logic                        i_out_ready,
   output logic                        o_busy
);

   localparam int unsigned    CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   state_t                      r_state;
   logic                        r_mem_en;
   logic [ADDR_WIDTH-1:0]       r_mem_addr;
   logic [CNT_W-1:0]            r_issue_cnt;
   logic [CNT_W-1:0]            r_cap_idx;
   logic [READ_LATENCY-1:0]     r_tag;
   logic [BEATS*DATA_WIDTH-1:0] r_data;
   logic                        r_data_valid;
   logic                        r_busy;

   logic w_start;
   logic w_capture;
   logic w_last_capture;

   rising_edge_detect u_trig_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_in    (i_trigger),
      .o_pulse (w_start)
   );

   // The tag leaving the pipeline marks the cycle in which a requested word is on i_mem_dout_b.
   assign w_capture      = r_tag[READ_LATENCY-1];
   assign w_last_capture = w_capture && (r_cap_idx == LAST_BEAT);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_mem_en     <= 1'b0;
         r_mem_addr   <= '0;
         r_issue_cnt  <= '0;
         r_data_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_state     <= StIssue;
                  r_mem_en    <= 1'b1;
                  r_mem_addr  <= i_base_addr;
                  r_issue_cnt <= '0;
                  r_busy      <= 1'b1;
               end
            end
            StIssue: begin
               if (r_issue_cnt == LAST_BEAT) begin
                  r_mem_en <= 1'b0;
                  r_state  <= StDrain;
               end else begin
                  r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                  r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
               end
            end
            StDrain: begin
               if (w_last_capture) begin
                  r_state      <= StHold;
                  r_data_valid <= 1'b1;
               end
            end
            StHold: begin
               if (i_out_ready) begin
                  r_state      <= StIdle;
                  r_data_valid <= 1'b0;
                  r_busy       <= 1'b0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_tag <= '0;
      end else begin
         r_tag[0] <= r_mem_en;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // Slots are not cleared at burst start; only data_valid qualifies the assembled word.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cap_idx <= '0;
         r_data    <= '0;
      end else if (w_start && (r_state == StIdle)) begin
         r_cap_idx <= '0;
      end else if (w_capture) begin
         r_cap_idx <= r_cap_idx + CNT_W'(1);
         for (int unsigned i = 0; i < BEATS; i++) begin
            if (r_cap_idx == CNT_W'(i)) begin
               r_data[i*DATA_WIDTH +: DATA_WIDTH] <= i_mem_dout_b;
            end
         end
      end
   end

   assign o_mem_en_b   = r_mem_en;
   assign o_mem_we_b   = 1'b0;
   assign o_mem_addr_b = r_mem_addr;
   assign o_data_out   = r_data;
   assign o_data_valid = r_data_valid;
   assign o_busy       = r_busy;

endmodule

// File: doc/memory_burst_reader.md
# memory_burst_reader

Reads a fixed-length burst of consecutive words from port B of a true dual-port memory and assembles them into one wide word. It is the read-side counterpart of the sequenced port-A writer, which stores a 128-bit value as four 32-bit words at consecutive addresses. A rising edge on `trigger` starts the burst. The assembled result is held under a valid/ready handshake until the consumer takes it.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, memory address width.
- `DATA_WIDTH`, 32, memory word width.
- `BEATS`, 4, words per burst (≥1).
- `READ_LATENCY`, 1, cycles from `mem_en_b` to valid `mem_dout_b` (≥1).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  level input; a rising edge starts a burst.
- `base_addr`  in  ADDR_WIDTH  first address; sampled on the start edge.
- `mem_en_b`  out  1  port-B enable.
- `mem_we_b`  out  1  port-B write enable; constant 0.
- `mem_addr_b`  out  ADDR_WIDTH  port-B address.
- `mem_dout_b`  in  DATA_WIDTH  port-B read data.
- `data_out`  out  BEATS*DATA_WIDTH  assembled word; beat i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `data_valid`  out  1  `data_out` is complete and stable.
- `out_ready`  in  1  consumer accepts `data_out`.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Edge detect: `start = trigger & ~trig_prev`. `trig_prev` resets to 1, so `trigger` held high through reset release does not start a burst.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
  - IDLE: on `start`, latch `base_addr`, clear the beat counters, go to ISSUE.
  - ISSUE: assert `mem_en_b` for BEATS consecutive cycles. `mem_addr_b` = base + k, k = 0..BEATS-1. Address arithmetic is modulo 2^ADDR_WIDTH, so 0xFFFF+1 wraps to 0x0000. After the last issue, go to DRAIN.
  - DRAIN: wait until all BEATS words are captured, then go to HOLD.
  - HOLD: `data_valid`=1. When `out_ready`=1, transfer and go to IDLE.
- Capture: a READ_LATENCY-deep shift register of issue tags marks each returning word. The word at tag output is written into slot `cap_idx`, then `cap_idx` increments. Slots are written only when their tag is valid.
- `data_out` holds its value after the transfer until overwritten by the next burst. Stale slots are not cleared at burst start; only `data_valid` qualifies `data_out`.
- `start` while `busy`=1 is dropped, not queued. This includes the HOLD transfer cycle.
- `mem_addr_b` holds its last value when `mem_en_b`=0.
- Reset values: `mem_en_b`=0, `mem_we_b`=0, `mem_addr_b`=0, `data_out`=0, `data_valid`=0, `busy`=0.
- Reset asserted mid-burst: return to IDLE immediately and clear the tag pipeline, so in-flight read data is discarded. The consumer never sees a partial word.

## Timing
- `start` true in cycle T → `mem_en_b`=1 in cycles T+1 .. T+BEATS.
- Beat k (enabled in T+1+k) is captured at the end of cycle T+1+k+READ_LATENCY.
- `data_valid` rises in cycle T+BEATS+READ_LATENCY+1. Defaults: T+6.
- Transfer occurs in the cycle where `data_valid` & `out_ready`.
- The next cycle is IDLE with `busy`=0, and a new `start` is accepted in that cycle.
- Minimum start-to-start spacing with `out_ready` held high: BEATS+READ_LATENCY+2 cycles (7 by default).
- `data_valid` and `data_out` are stable while `out_ready`=0, with no limit on stall length.

## Structure
- Shared package `memory_burst_pkg`:
  - FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, HOLD=3).
  - Default constants: BEATS=4, DATA_WIDTH=32, ADDR_WIDTH=16. The writer uses the same constants.
- Sub-module `rising_edge_detect` (`clk`, `reset`, `in`, `pulse`) with reset value 1 for the previous-sample register. It is reusable by the writer side.
- Everything else stays in one module: FSM, issue counter, tag pipeline, capture registers.

## Test plan
- Basic burst: preload addrs 1..4 with 0x11111111, 0x22222222, 0x33333333, 0x44444444. Set `base_addr`=1, pulse `trigger`, hold `out_ready`=1. Expect `data_out`=0x44444444_33333333_22222222_11111111, with `data_valid` high exactly at T+6 for one cycle.
- Back-pressure: repeat with `out_ready`=0 for 10 cycles after `data_valid`. Expect `data_out` stable and `data_valid` held. Raise `out_ready`; expect IDLE the next cycle.
- Address wrap: `base_addr`=0xFFFE. Expect `mem_addr_b` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, and data assembled in that order.
- Dropped triggers: toggle `trigger` every cycle during a burst and on the transfer cycle. Expect exactly one burst and no second `mem_en_b` run. A rising edge in the first cycle with `busy`=0 starts a new burst.
- Reset mid-burst: assert `reset` at T+3. Expect all outputs at reset values and no `data_valid` afterward. Hold `trigger` high across release and expect no burst until `trigger` falls and rises again.
- Latency parameter: with READ_LATENCY=3 and the basic-burst preload, expect `data_valid` at T+8 and a correct beat order.
